// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Receives bytes from the UART receiver, assembles them little-endian into
//   INST_SZ-bit instructions and writes each one into instruction memory
//   through the fetch stage's write port. Once a program has been loaded, it
//   drives the pipeline enable in continuous (RUN) or single-step (STEP) mode
//   until the pipeline reports a halt.
//
// Ports
//   i_clk            clock
//   i_reset          synchronous, active-high reset
//   i_rx_data        received byte, valid while i_rx_done=1
//   i_rx_done        one-cycle strobe per received byte
//   i_halt           pipeline has retired HALT_INST (level)
//   o_write          one-cycle instruction memory write strobe
//   o_instruction_F  assembled instruction word (holds between writes)
//   o_addr           byte address of the word written (word index * 4)
//   o_enable         pipeline execution enable
//   o_state          current FSM state (debug)
//   o_overflow       program exceeded MEM_WORDS without a HALT_INST
//
// Handshake: there is no back-pressure. A byte is consumed in every cycle in
// which i_rx_done=1, including a cycle in which o_write=1, and o_write is a
// single-cycle strobe that the memory must accept unconditionally.
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int              INST_SZ   = 32,
    parameter int              PC_SZ     = 32,
    parameter int              DATA_SZ   = 8,
    parameter int              MEM_WORDS = 64,
    parameter logic [INST_SZ-1:0] HALT_INST = 32'hFFFFFFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [DATA_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_halt,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction_F,
    output logic [PC_SZ-1:0]   o_addr,
    output logic               o_enable,
    output logic [2:0]         o_state,
    output logic               o_overflow
);

    // One extra bit so the index can represent MEM_WORDS itself.
    localparam int WIDX_SZ = $clog2(MEM_WORDS) + 1;
    localparam int ASM_SZ  = INST_SZ - DATA_SZ;

    localparam logic [DATA_SZ-1:0] CMD_L = DATA_SZ'(8'h4C);
    localparam logic [DATA_SZ-1:0] CMD_C = DATA_SZ'(8'h43);
    localparam logic [DATA_SZ-1:0] CMD_S = DATA_SZ'(8'h53);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [ASM_SZ-1:0]    asm_q, asm_d;
    logic [WIDX_SZ-1:0]   word_idx_q, word_idx_d;
    logic                 loaded_q, loaded_d;
    logic                 overflow_q, overflow_d;
    logic                 write_q, write_d;
    logic [INST_SZ-1:0]   instr_q, instr_d;
    logic [PC_SZ-1:0]     addr_q, addr_d;
    logic                 enable_q, enable_d;
    logic [INST_SZ-1:0]   word_full;

    // The first three bytes live in asm_q; the fourth completes the word.
    assign word_full = {i_rx_data, asm_q};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            word_idx_q <= '0;
            loaded_q   <= 1'b0;
            overflow_q <= 1'b0;
            write_q    <= 1'b0;
            instr_q    <= '0;
            addr_q     <= '0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            word_idx_q <= word_idx_d;
            loaded_q   <= loaded_d;
            overflow_q <= overflow_d;
            write_q    <= write_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            enable_q   <= enable_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        word_idx_d = word_idx_q;
        loaded_d   = loaded_q;
        overflow_d = overflow_q;
        write_d    = 1'b0;
        instr_d    = instr_q;
        addr_d     = addr_q;
        enable_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_L) begin
                        state_d    = LOAD;
                        byte_cnt_d = '0;
                        word_idx_d = '0;
                        loaded_d   = 1'b0;
                        overflow_d = 1'b0;
                    end else if (i_rx_data == CMD_C && loaded_q) begin
                        state_d  = RUN;
                        enable_d = 1'b1;
                    end else if (i_rx_data == CMD_S && loaded_q) begin
                        state_d = STEP;
                    end
                end
            end

            LOAD: begin
                if (i_rx_done) begin
                    if (byte_cnt_q == 2'd3) begin
                        write_d    = 1'b1;
                        instr_d    = word_full;
                        addr_d     = PC_SZ'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + WIDX_SZ'(1);
                        byte_cnt_d = '0;
                        // HALT_INST wins over overflow, so a HALT in the last
                        // memory slot is still a normal load.
                        if (word_full == HALT_INST) begin
                            loaded_d = 1'b1;
                            state_d  = IDLE;
                        end else if (word_idx_q == WIDX_SZ'(MEM_WORDS - 1)) begin
                            overflow_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        // Shift-in from the top: after three bytes the first
                        // one has reached the least significant position.
                        asm_d      = {i_rx_data, asm_q[ASM_SZ-1:DATA_SZ]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            RUN: begin
                if (i_halt) begin
                    state_d = DONE;
                end else begin
                    enable_d = 1'b1;
                end
            end

            STEP: begin
                // Halt takes priority over a same-cycle step request.
                if (i_halt) begin
                    state_d = DONE;
                end else if (i_rx_done && i_rx_data == CMD_C) begin
                    state_d  = RUN;
                    enable_d = 1'b1;
                end else if (i_rx_done && i_rx_data == CMD_S) begin
                    enable_d = 1'b1;
                end
            end

            DONE: begin
                if (i_rx_done && i_rx_data == CMD_L) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    loaded_d   = 1'b0;
                    overflow_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_write         = write_q;
    assign o_instruction_F = instr_q;
    assign o_addr          = addr_q;
    assign o_enable        = enable_q;
    assign o_state         = state_q;
    assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int INST_SZ   = 32;
    localparam int PC_SZ     = 32;
    localparam int DATA_SZ   = 8;
    localparam int MEM_WORDS = 4;

    logic               clk;
    logic               reset;
    logic [DATA_SZ-1:0] rx_data;
    logic               rx_done;
    logic               halt;
    logic               o_write;
    logic [INST_SZ-1:0] o_instruction_F;
    logic [PC_SZ-1:0]   o_addr;
    logic               o_enable;
    logic [2:0]         o_state;
    logic               o_overflow;

    // Expected writes: {address, instruction}
    logic [PC_SZ+INST_SZ-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    prog_loader #(
        .INST_SZ  (INST_SZ),
        .PC_SZ    (PC_SZ),
        .DATA_SZ  (DATA_SZ),
        .MEM_WORDS(MEM_WORDS),
        .HALT_INST(32'hFFFFFFFF)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_data      (rx_data),
        .i_rx_done      (rx_done),
        .i_halt         (halt),
        .o_write        (o_write),
        .o_instruction_F(o_instruction_F),
        .o_addr         (o_addr),
        .o_enable       (o_enable),
        .o_state        (o_state),
        .o_overflow     (o_overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every write against the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_enable) en_cnt++;
            if (o_write) begin
                check("write_vs_enable", {63'd0, o_enable}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {32'd0, o_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [PC_SZ+INST_SZ-1:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", {32'd0, o_addr}, {32'd0, e[PC_SZ+INST_SZ-1:INST_SZ]});
                    check("write_data", {32'd0, o_instruction_F}, {32'd0, e[INST_SZ-1:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] a);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Back-to-back bytes: rx_done held high, one byte per cycle.
    task automatic stream_word(input logic [31:0] w, input logic [31:0] a);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            rx_data = w[8*i +: 8];
            rx_done = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_halt();
        @(posedge clk); #1;
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int en0;
        reset   = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h4C;
        halt    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {61'd0, o_state}, 64'd0);
        check("rst_write", {63'd0, o_write}, 64'd0);
        check("rst_enable", {63'd0, o_enable}, 64'd0);
        check("rst_overflow", {63'd0, o_overflow}, 64'd0);
        check("rst_instr", {32'd0, o_instruction_F}, 64'd0);
        check("rst_addr", {32'd0, o_addr}, 64'd0);
        reset   = 1'b0;
        rx_done = 1'b0;

        // Load three words ending with HALT
        send_byte(8'h4C);
        check("load_state", {61'd0, o_state}, 64'd1);
        send_word(32'h12345678, 32'd0);
        send_word(32'h00000001, 32'd4);
        send_word(32'hFFFFFFFF, 32'd8);
        check("halt_load_state", {61'd0, o_state}, 64'd0);
        check("halt_load_ovf", {63'd0, o_overflow}, 64'd0);
        repeat (3) @(posedge clk); #1;
        check("hold_instr", {32'd0, o_instruction_F}, 64'hFFFFFFFF);
        check("hold_addr", {32'd0, o_addr}, 64'd8);

        // Continuous run, then halt
        send_byte(8'h43);
        check("run_state", {61'd0, o_state}, 64'd2);
        for (int i = 0; i < 4; i++) begin
            check("run_enable", {63'd0, o_enable}, 64'd1);
            @(posedge clk); #1;
        end
        pulse_halt();
        check("halt_enable", {63'd0, o_enable}, 64'd0);
        check("done_state", {61'd0, o_state}, 64'd4);
        send_byte(8'h43);
        check("done_ignore_c", {61'd0, o_state}, 64'd4);
        send_byte(8'h53);
        check("done_ignore_s", {61'd0, o_state}, 64'd4);
        check("done_enable", {63'd0, o_enable}, 64'd0);

        // Reload from DONE, then single-step
        send_byte(8'h4C);
        send_word(32'hCAFEF00D, 32'd0);
        send_word(32'hFFFFFFFF, 32'd4);
        send_byte(8'h53);
        check("step_state", {61'd0, o_state}, 64'd3);
        check("step_idle_en", {63'd0, o_enable}, 64'd0);
        en0 = en_cnt;
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(posedge clk);
            send_byte(8'h53);
            check("step_pulse", {63'd0, o_enable}, 64'd1);
            @(posedge clk); #1;
            check("step_pulse_end", {63'd0, o_enable}, 64'd0);
        end
        check("step_pulse_count", 64'(en_cnt - en0), 64'd3);
        send_byte(8'h43);
        check("step_to_run", {61'd0, o_state}, 64'd2);
        repeat (3) @(posedge clk); #1;
        check("step_to_run_en", {63'd0, o_enable}, 64'd1);
        pulse_halt();

        // Halt beats a same-cycle step request
        send_byte(8'h4C);
        send_word(32'hFFFFFFFF, 32'd0);
        send_byte(8'h53);
        @(posedge clk); #1;
        rx_data = 8'h53;
        rx_done = 1'b1;
        halt    = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        halt    = 1'b0;
        check("halt_prio_state", {61'd0, o_state}, 64'd4);
        check("halt_prio_en", {63'd0, o_enable}, 64'd0);

        // Overflow: MEM_WORDS words with no HALT
        send_byte(8'h4C);
        send_word(32'h0A0A0A0A, 32'd0);
        send_word(32'h0B0B0B0B, 32'd4);
        send_word(32'h0C0C0C0C, 32'd8);
        send_word(32'h0D0D0D0D, 32'd12);
        check("ovf_flag", {63'd0, o_overflow}, 64'd1);
        check("ovf_state", {61'd0, o_state}, 64'd0);
        send_byte(8'h43);
        check("ovf_c_state", {61'd0, o_state}, 64'd0);
        check("ovf_c_enable", {63'd0, o_enable}, 64'd0);
        send_byte(8'h4C);
        check("ovf_cleared", {63'd0, o_overflow}, 64'd0);
        check("ovf_reload_state", {61'd0, o_state}, 64'd1);

        // Reset mid-word discards partial bytes
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_state", {61'd0, o_state}, 64'd0);
        send_byte(8'h4C);
        send_word(32'hDDCCBBAA, 32'd0);

        // Streamed bytes across write cycles; HALT in the last slot is normal
        stream_word(32'h44332211, 32'd4);
        stream_word(32'h88776655, 32'd8);
        stream_word(32'hFFFFFFFF, 32'd12);
        rx_done = 1'b0;
        check("last_slot_halt_ovf", {63'd0, o_overflow}, 64'd0);
        check("last_slot_halt_state", {61'd0, o_state}, 64'd0);
        send_byte(8'h43);
        check("last_slot_run", {61'd0, o_state}, 64'd2);
        check("last_slot_run_en", {63'd0, o_enable}, 64'd1);
        pulse_halt();

        repeat (4) @(posedge clk); #1;
        check("writes_outstanding", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and execution controller sitting directly upstream of the fetch stage. It takes bytes from the UART receiver and assembles them into 32-bit instructions. It writes each word into instruction memory through the fetch stage's write port (write line, instruction data, address). Once a program is loaded, it drives the pipeline enable in either continuous or single-step mode until the pipeline reports a halt.

## Interface
- INST_SZ, 32, instruction width; must be 4 × DATA_SZ
- PC_SZ, 32, address width
- DATA_SZ, 8, UART byte width
- MEM_WORDS, 64, instruction memory capacity in words
- HALT_INST, 32'hFFFFFFFF, end-of-program marker word
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  DATA_SZ  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle strobe per received byte
- i_halt  in  1  pipeline has retired HALT_INST (level)
- o_write  out  1  one-cycle instruction memory write strobe
- o_instruction_F  out  INST_SZ  assembled instruction word
- o_addr  out  PC_SZ  byte address of the word being written (word index × 4)
- o_enable  out  1  pipeline execution enable
- o_state  out  3  current FSM state (debug)
- o_overflow  out  1  set when the program exceeds MEM_WORDS without a HALT_INST

## Operation
- States and encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4.
- IDLE, on command byte:
  - 'L' (0x4C) → LOAD; clears word index, byte counter, loaded flag and o_overflow.
  - 'C' (0x43) → RUN, only if the loaded flag is set.
  - 'S' (0x53) → STEP, only if the loaded flag is set.
  - Any other byte is ignored.
- LOAD, byte assembly:
  - Bytes are assembled little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - A 2-bit byte counter wraps 3→0.
  - When the fourth byte arrives, the word is registered to o_instruction_F and o_write pulses.
  - o_addr = word index × 4; the word index then increments.
- LOAD, exit conditions:
  - If the word is HALT_INST: it is still written, the loaded flag is set, and the FSM → IDLE.
  - If the word index reaches MEM_WORDS and the word is not HALT_INST: o_overflow=1, loaded flag stays 0, and the FSM → IDLE.
  - If the word at index MEM_WORDS-1 is HALT_INST, that is a normal load, not an overflow.
- RUN:
  - o_enable=1 every cycle.
  - i_halt=1 → DONE.
  - Command bytes are ignored.
- STEP:
  - o_enable=0 by default.
  - Each 'S' byte produces exactly one cycle of o_enable=1.
  - A 'C' byte → RUN.
  - i_halt=1 → DONE; this takes priority over a same-cycle 'S'.
- DONE:
  - o_enable=0.
  - 'L' → LOAD (full reload).
  - 'C' and 'S' are ignored until a new load completes.
- Invariants:
  - o_write and o_enable are never both 1.
  - o_instruction_F and o_addr hold their last value between writes.

## Timing
- Reset: state=IDLE; o_write, o_enable and o_overflow = 0; o_instruction_F and o_addr = 0; counters and loaded flag = 0.
- Reset has priority over every other input and aborts a load mid-word; partial bytes are discarded.
- Write latency: if i_rx_done with the 4th byte is at cycle t, then o_write=1 at t+1 with o_instruction_F and o_addr valid that cycle. o_write=0 at t+2.
- A byte strobe in the same cycle as o_write=1 is accepted as byte 0 of the next word.
- Command latency: a command byte at t → new state and o_enable updated at t+1.
- Step latency: an 'S' at t → o_enable=1 at t+1 only.
- Halt latency: i_halt sampled at t → o_enable=0 from t+1.
- i_rx_done is only acted on in the cycle it is high; a held-high strobe counts as one byte per cycle.

## Test plan
- Reset with i_rx_done=1, byte 0x4C → state stays 0 and all outputs are 0; after reset is released, 'L' → o_state=1.
- 'L', then bytes 78 56 34 12 → one-cycle o_write with o_instruction_F=0x12345678 and o_addr=0. Next bytes 01 00 00 00 → o_instruction_F=0x00000001, o_addr=4.
- Load two words plus FF FF FF FF → third write at o_addr=8, then o_state=0. 'C' → o_enable=1 continuously; i_halt pulse → o_enable=0 next cycle, o_state=4.
- After a load: 'S', 'S', 'S' spaced 10 cycles apart → exactly three single-cycle o_enable pulses. Then 'C' → continuous enable.
- MEM_WORDS=4: load 4 non-halt words → 4 writes, o_overflow=1, o_state=0. 'C' ignored (o_enable stays 0). 'L' clears o_overflow.
- Reset asserted after 2 bytes of a word, then 'L' and 4 bytes AA BB CC DD → o_instruction_F=0xDDCCBBAA, o_addr=0 (partial bytes discarded).
